// File: rtl/pu_acc_sched.sv
// Window accumulator sequencer for the pooling unit: sums each window of signed samples
// through a two-operand adder and hands out one sum per window on a valid/ready port.

module pu_adder2 #(
    parameter int INPUT_WD1 = 20,
    parameter int INPUT_WD2 = 16,
    parameter int OUTPUT_WD = 20
) (
    input  logic signed [INPUT_WD1-1:0] op1,
    input  logic signed [INPUT_WD2-1:0] op2,
    output logic signed [OUTPUT_WD-1:0] sum
);
    assign sum = OUTPUT_WD'(op1) + OUTPUT_WD'(op2);
endmodule

module pu_acc_sched #(
    parameter int IN_WD  = 16,
    parameter int ACC_WD = 20,
    parameter int LEN_WD = 8,
    parameter int NUM_WD = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [LEN_WD-1:0]        win_len_i,
    input  logic [NUM_WD-1:0]        win_num_i,
    output logic                     busy_o,
    output logic                     done_o,
    input  logic                     in_vld_i,
    input  logic signed [IN_WD-1:0]  in_dat_i,
    output logic                     in_rdy_o,
    output logic                     out_vld_o,
    input  logic                     out_rdy_i,
    output logic signed [ACC_WD-1:0] out_dat_o,
    output logic                     out_ovf_o
);
    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t                    state;
    state_t                    state_next;
    logic [LEN_WD-1:0]         len;
    logic [LEN_WD-1:0]         elem_cnt;
    logic [NUM_WD-1:0]         num;
    logic [NUM_WD-1:0]         win_cnt;
    logic signed [ACC_WD-1:0]  acc;
    logic signed [ACC_WD-1:0]  sum;
    logic                      ovf;
    logic                      done;
    logic                      start_ok;
    logic                      in_hs;
    logic                      out_hs;
    logic                      last_elem;
    logic                      last_win;
    logic                      add_ovf;

    pu_adder2 #(
        .INPUT_WD1 (ACC_WD),
        .INPUT_WD2 (IN_WD),
        .OUTPUT_WD (ACC_WD)
    ) u_add (
        .op1 (acc),
        .op2 (in_dat_i),
        .sum (sum)
    );

    assign start_ok  = (state == IDLE) && start_i && (win_len_i != '0) && (win_num_i != '0);
    assign in_hs     = (state == ACC) && in_vld_i;
    assign out_hs    = (state == OUT) && out_rdy_i;
    assign last_elem = (elem_cnt == len - 1'b1);
    assign last_win  = (win_cnt == num - 1'b1);
    // Signed overflow: both operands share a sign that the wrapped result does not.
    assign add_ovf   = (acc[ACC_WD-1] == in_dat_i[IN_WD-1]) && (sum[ACC_WD-1] != acc[ACC_WD-1]);

    always_comb begin
        state_next = state;
        in_rdy_o   = 1'b0;
        out_vld_o  = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) state_next = ACC;
            end
            ACC: begin
                in_rdy_o = 1'b1;
                if (in_vld_i && last_elem) state_next = OUT;
            end
            OUT: begin
                out_vld_o = 1'b1;
                if (out_rdy_i) state_next = last_win ? IDLE : ACC;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            len      <= '0;
            num      <= '0;
            elem_cnt <= '0;
            win_cnt  <= '0;
            acc      <= '0;
            ovf      <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_next;
            done  <= out_hs && last_win;
            if (start_ok) begin
                len      <= win_len_i;
                num      <= win_num_i;
                elem_cnt <= '0;
                win_cnt  <= '0;
                acc      <= '0;
                ovf      <= 1'b0;
            end
            if (in_hs) begin
                acc      <= sum;
                ovf      <= ovf | add_ovf;
                elem_cnt <= elem_cnt + 1'b1;
            end
            // Finished window that is not the last one: rearm for the next window.
            if (out_hs && !last_win) begin
                win_cnt  <= win_cnt + 1'b1;
                elem_cnt <= '0;
                acc      <= '0;
                ovf      <= 1'b0;
            end
        end
    end

    assign busy_o    = (state != IDLE);
    assign done_o    = done;
    assign out_dat_o = acc;
    assign out_ovf_o = ovf && (state == OUT);

endmodule

// File: tb/tb_pu_acc_sched.sv
// Randomized self-checking bench for pu_acc_sched; expected window sums and overflow
// flags come from plain integer arithmetic over the generated sample stream.

module tb_pu_acc_sched;
    localparam int IN_WD  = 16;
    localparam int ACC_WD = 16;
    localparam int LEN_WD = 8;
    localparam int NUM_WD = 16;
    localparam int BUDGET = 4000;
    localparam longint ACC_HALF = longint'(1) << (ACC_WD - 1);

    logic                     clk_i;
    logic                     rst_i;
    logic                     start_i;
    logic [LEN_WD-1:0]        win_len_i;
    logic [NUM_WD-1:0]        win_num_i;
    logic                     busy_o;
    logic                     done_o;
    logic                     in_vld_i;
    logic signed [IN_WD-1:0]  in_dat_i;
    logic                     in_rdy_o;
    logic                     out_vld_o;
    logic                     out_rdy_i;
    logic signed [ACC_WD-1:0] out_dat_o;
    logic                     out_ovf_o;

    int checks = 0;
    int errors = 0;
    int sample_q[$];

    pu_acc_sched #(
        .IN_WD  (IN_WD),
        .ACC_WD (ACC_WD),
        .LEN_WD (LEN_WD),
        .NUM_WD (NUM_WD)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .win_len_i (win_len_i),
        .win_num_i (win_num_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .in_vld_i  (in_vld_i),
        .in_dat_i  (in_dat_i),
        .in_rdy_o  (in_rdy_o),
        .out_vld_o (out_vld_o),
        .out_rdy_i (out_rdy_i),
        .out_dat_o (out_dat_o),
        .out_ovf_o (out_ovf_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                               input logic signed [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    function automatic longint wrapAcc(input longint v);
        longint r;
        r = v % (2 * ACC_HALF);
        if (r < 0) r += 2 * ACC_HALF;
        if (r >= ACC_HALF) r -= 2 * ACC_HALF;
        return r;
    endfunction

    function automatic int randSample();
        return int'($urandom_range(0, (1 << IN_WD) - 1)) - (1 << (IN_WD - 1));
    endfunction

    // Runs one whole job: preset samples come from sample_q, the rest are random.
    task automatic applyStimulus(input int len, input int num, input int vld_pct,
                                 input int rdy_pct, input int stall, input bit poke);
        int     drive_q[$];
        longint exp_sum_q[$];
        bit     exp_ovf_q[$];
        longint acc_m;
        longint raw;
        bit     ovf_m;
        int     s;
        int     elem;
        int     cycles;
        int     stall_left;
        bit     vld_seen;
        bit     lat_pending;
        bit     done_exp;
        bit     finished;

        for (int w = 0; w < num; w++) begin
            acc_m = 0;
            ovf_m = 1'b0;
            for (int e = 0; e < len; e++) begin
                s = (sample_q.size() > 0) ? sample_q.pop_front() : randSample();
                drive_q.push_back(s);
                raw = acc_m + longint'(s);
                if (raw >= ACC_HALF || raw < -ACC_HALF) ovf_m = 1'b1;
                acc_m = wrapAcc(raw);
            end
            exp_sum_q.push_back(acc_m);
            exp_ovf_q.push_back(ovf_m);
        end

        start_i   = 1'b1;
        win_len_i = LEN_WD'(len);
        win_num_i = NUM_WD'(num);
        nextCycle();
        start_i = 1'b0;
        checkOutput("busy_start", busy_o, 1);

        elem = 0; cycles = 0; stall_left = 0;
        vld_seen = 0; lat_pending = 0; done_exp = 0; finished = 0;
        while (!finished) begin
            start_i = 1'b0;
            checkOutput("done", done_o, done_exp);
            if (done_exp) begin
                checkOutput("busy_end", busy_o, 0);
                finished = 1;
            end else begin
                if (lat_pending) checkOutput("latency", out_vld_o, 1);
                lat_pending = 0;
                if (out_vld_o) checkOutput("bubble", in_rdy_o, 0);

                in_vld_i = (drive_q.size() > 0) && ($urandom_range(0, 99) < vld_pct);
                in_dat_i = (drive_q.size() > 0) ? IN_WD'(drive_q[0]) : '0;
                out_rdy_i = ($urandom_range(0, 99) < rdy_pct);
                if (out_vld_o) begin
                    if (!vld_seen) begin
                        vld_seen   = 1;
                        stall_left = stall;
                    end
                    if (stall_left > 0) begin
                        out_rdy_i = 1'b0;
                        stall_left--;
                        if (exp_sum_q.size() > 0) begin
                            checkOutput("hold_dat", out_dat_o, exp_sum_q[0]);
                            checkOutput("hold_ovf", out_ovf_o, exp_ovf_q[0]);
                        end
                    end
                end
                if (poke) begin
                    start_i   = 1'b1;
                    win_len_i = LEN_WD'($urandom_range(1, 9));
                    win_num_i = NUM_WD'($urandom_range(1, 9));
                end

                if (in_vld_i && in_rdy_o) begin
                    void'(drive_q.pop_front());
                    elem++;
                    if (elem == len) begin
                        elem = 0;
                        lat_pending = 1;
                    end
                end
                if (out_vld_o && out_rdy_i) begin
                    if (exp_sum_q.size() > 0) begin
                        checkOutput("sum", out_dat_o, exp_sum_q.pop_front());
                        checkOutput("ovf", out_ovf_o, exp_ovf_q.pop_front());
                    end else begin
                        checkOutput("extra_window", out_vld_o, 0);
                    end
                    vld_seen = 0;
                    if (exp_sum_q.size() == 0) done_exp = 1;
                end
                cycles++;
                if (cycles > BUDGET) begin
                    checkOutput("timeout_windows_left", exp_sum_q.size(), 0);
                    finished = 1;
                end
                nextCycle();
            end
        end
        start_i   = 1'b0;
        in_vld_i  = 1'b0;
        out_rdy_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; win_len_i = '0; win_num_i = '0;
        in_vld_i = 1'b0; in_dat_i = '0; out_rdy_i = 1'b0;
        repeat (3) nextCycle();
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_done", done_o, 0);
        checkOutput("rst_in_rdy", in_rdy_o, 0);
        checkOutput("rst_out_vld", out_vld_o, 0);
        checkOutput("rst_out_dat", out_dat_o, 0);
        checkOutput("rst_out_ovf", out_ovf_o, 0);
        rst_i = 1'b0;
        nextCycle();

        $display("[TB] basic sum of four samples");
        sample_q = '{1, 2, 3, 4};
        applyStimulus(4, 1, 100, 100, 0, 0);

        $display("[TB] two windows with output stalls");
        sample_q = '{-5, 2, 1, 7, -8, -1};
        applyStimulus(3, 2, 100, 100, 3, 0);

        $display("[TB] signed overflow then clean window");
        sample_q = '{32767, 32767, 1, 1};
        applyStimulus(2, 2, 100, 100, 0, 0);

        $display("[TB] starts with a zero field are ignored");
        start_i = 1'b1; win_len_i = '0; win_num_i = NUM_WD'(3);
        nextCycle();
        checkOutput("zero_len_busy", busy_o, 0);
        checkOutput("zero_len_rdy", in_rdy_o, 0);
        win_len_i = LEN_WD'(3); win_num_i = '0;
        nextCycle();
        start_i = 1'b0;
        checkOutput("zero_num_busy", busy_o, 0);
        checkOutput("zero_num_rdy", in_rdy_o, 0);

        $display("[TB] start while busy does not disturb the job");
        applyStimulus(3, 3, 80, 80, 1, 1);

        $display("[TB] reset in the middle of a window");
        start_i = 1'b1; win_len_i = LEN_WD'(4); win_num_i = NUM_WD'(1);
        nextCycle();
        start_i = 1'b0;
        in_vld_i = 1'b1; in_dat_i = 16'sd5;
        nextCycle();
        in_dat_i = 16'sd6;
        nextCycle();
        in_vld_i = 1'b0; rst_i = 1'b1;
        nextCycle();
        rst_i = 1'b0;
        checkOutput("abort_busy", busy_o, 0);
        checkOutput("abort_done", done_o, 0);
        checkOutput("abort_in_rdy", in_rdy_o, 0);
        checkOutput("abort_out_vld", out_vld_o, 0);
        checkOutput("abort_out_dat", out_dat_o, 0);
        checkOutput("abort_out_ovf", out_ovf_o, 0);
        sample_q = '{3, 4};
        applyStimulus(2, 1, 100, 100, 0, 0);

        $display("[TB] single-sample windows with random gaps");
        applyStimulus(1, 5, 60, 60, 0, 0);

        $display("[TB] random jobs");
        for (int j = 0; j < 8; j++)
            applyStimulus($urandom_range(1, 6), $urandom_range(1, 4), 70, 70,
                          $urandom_range(0, 2), 1'($urandom_range(0, 1)));

        $display("[TB] longest window length");
        applyStimulus(255, 2, 100, 100, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
